// File: rtl/rx_ram_fifo_ctrl.sv
// rtl/rx_ram_fifo_ctrl.sv - first-word-fall-through FIFO controller over an external dual-port RAM
// Port A writes and port B reads; a 2-entry head/skid stage hides the RAM's registered read latency.
module rx_ram_fifo_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [AWIDTH-1:0] ram_addra,
    output logic [DWIDTH-1:0] ram_dia,
    output logic              ram_enb,
    output logic [AWIDTH-1:0] ram_addrb,
    input  logic [DWIDTH-1:0] ram_dob,
    output logic [AWIDTH+1:0] count,
    output logic              full,
    output logic              overflow
);

    localparam logic [AWIDTH:0] DEPTH_CNT = {1'b1, {AWIDTH{1'b0}}};

    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_rd_ptr;
    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] r_skid;
    logic [1:0]        r_stg_cnt;
    logic              r_rd_pend;
    logic              r_overflow;

    logic [AWIDTH:0]   w_ram_cnt;
    logic              w_full;
    logic              w_wr;
    logic              w_pop;
    logic              w_rd;
    logic [2:0]        w_occ;

    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_ram_cnt == DEPTH_CNT);
    assign w_wr      = in_valid & ~w_full & ~clear;
    assign w_pop     = (r_stg_cnt != 2'd0) & out_ready & ~clear;

    // Issue a read only if the stage can still hold it after this cycle's pop.
    assign w_occ = {1'b0, r_stg_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_rd  = ~clear & (w_ram_cnt != '0) & (w_occ < 3'd2);

    assign in_ready  = ~w_full;
    assign full      = w_full;
    assign ram_ena   = w_wr;
    assign ram_wea   = w_wr;
    assign ram_addra = r_wr_ptr[AWIDTH-1:0];
    assign ram_dia   = in_data;
    assign ram_enb   = w_rd;
    assign ram_addrb = r_rd_ptr[AWIDTH-1:0];
    assign out_data  = r_head;
    assign out_valid = (r_stg_cnt != 2'd0);
    assign overflow  = r_overflow;
    assign count     = {1'b0, w_ram_cnt}
                     + {{(AWIDTH+1){1'b0}}, r_rd_pend}
                     + {{AWIDTH{1'b0}}, r_stg_cnt};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_head     <= '0;
            r_skid     <= '0;
            r_stg_cnt  <= 2'd0;
            r_rd_pend  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_stg_cnt  <= 2'd0;
            r_rd_pend  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_pend <= w_rd;
            if (in_valid & w_full) begin
                r_overflow <= 1'b1;
            end
            r_stg_cnt <= r_stg_cnt - {1'b0, w_pop} + {1'b0, r_rd_pend};
            // Returning read data lands behind whatever is older in the stage.
            if (w_pop) begin
                if (r_stg_cnt == 2'd2) begin
                    r_head <= r_skid;
                    if (r_rd_pend) begin
                        r_skid <= ram_dob;
                    end
                end else if (r_rd_pend) begin
                    r_head <= ram_dob;
                end
            end else if (r_rd_pend) begin
                if (r_stg_cnt == 2'd0) begin
                    r_head <= ram_dob;
                end else begin
                    r_skid <= ram_dob;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_ram_fifo_ctrl.sv
// tb/tb_rx_ram_fifo_ctrl.sv - scoreboard bench for rx_ram_fifo_ctrl with a behavioural RAM
module tb_rx_ram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob = '0;
    logic [AW+1:0] count;
    logic          full;
    logic          overflow;

    rx_ram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    int            m_count = 0;
    logic          m_ovf = 1'b0;
    logic          last_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples 3 ns after the falling edge, pops the scoreboard on each handshake.
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge clock);
            #3;
            if (reset_n) begin
                chk("count", 64'(count), 64'(m_count));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                chk("in_ready_vs_full", 64'(in_ready), 64'(!full));
                if (m_count < DEPTH) chk("full_low", 64'(full), 64'd0);
                if (m_count == DEPTH + 2) chk("full_high", 64'(full), 64'd1);
                if (out_valid && out_ready && !clear) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got %0h expected no word", out_data);
                    end else begin
                        exp_w = sb.pop_front();
                        chk("out_data", 64'(out_data), 64'(exp_w));
                    end
                    m_count--;
                end
            end
        end
    end

    task automatic flush_model();
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    // One cycle of stimulus; returns 1 ns before the rising edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        @(negedge clock);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        #4;
        last_acc = 1'b0;
        if (!reset_n || c) begin
            flush_model();
        end else if (v && in_ready) begin
            sb.push_back(d);
            m_count++;
            last_acc = 1'b1;
        end else if (v) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int acc;
        // Reset with a write presented: nothing may be stored.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_enb", 64'(ram_enb), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;

        // Single write latency.
        cyc(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
        chk("lat_acc", 64'(last_acc), 64'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lat_enb_n1", 64'(ram_enb), 64'd1);
        chk("lat_valid_n1", 64'(out_valid), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lat_valid_n2", 64'(out_valid), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lat_valid_n3", 64'(out_valid), 64'd1);
        chk("lat_data_n3", 64'(out_data), 64'hA5A5_A5A5);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lat_valid_n4", 64'(out_valid), 64'd0);

        // Continuous streaming.
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, DW'(i), 1'b1, 1'b0);
            chk("stream_acc", 64'(last_acc), 64'd1);
            if (i >= 3) chk("stream_bubble", 64'(out_valid), 64'd1);
            chk("stream_count_le3", 64'(count <= 3), 64'd1);
        end
        drain();

        // Fill with the consumer stalled: capacity is DEPTH+2.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0);
            if (last_acc) acc++;
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("fill_accepted", 64'(acc), 64'(DEPTH + 2));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'(DEPTH + 2));
        chk("fill_overflow", 64'(overflow), 64'd1);
        drain();

        // Clear right after a read issue with both stage entries occupied.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("clr_read_issue", 64'(ram_enb), 64'd1);
        cyc(1'b1, 32'h0000_0BAD, 1'b0, 1'b1);
        chk("clr_wea_forced", 64'(ram_wea), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("clr_valid_n1", 64'(out_valid), 64'd0);
        chk("clr_count_n1", 64'(count), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("clr_valid_n2", 64'(out_valid), 64'd0);
        cyc(1'b1, 32'h0000_0001, 1'b1, 1'b0);
        drain();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 199) == 0));
        end
        drain();

        // Asynchronous reset pulse mid-stream.
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'(500 + i), 1'b1, 1'b0);
        @(negedge clock);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_enb", 64'(ram_enb), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        flush_model();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(700 + i), 1'($urandom_range(0, 1)), 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
